// File: rtl/alu_rs_pkg.sv
// rtl/alu_rs_pkg.sv - shared core encodings and reservation-station entry type
package alu_rs_pkg;

  localparam int TAG_W = 7;
  localparam int ROB_W = 3;
  localparam int XLEN  = 32;

  // Major opcodes (instruction bits [6:2])
  localparam logic [4:0] OP_R_TYPE = 5'b01100;
  localparam logic [4:0] OP_I_TYPE = 5'b00100;
  localparam logic [4:0] OP_LUI    = 5'b01101;
  localparam logic [4:0] OP_AUIPC  = 5'b00101;
  localparam logic [4:0] OP_JAL    = 5'b11011;

  // ALU funct3 encodings
  localparam logic [2:0] F3_ADD_SUB = 3'b000;
  localparam logic [2:0] F3_SLL     = 3'b001;
  localparam logic [2:0] F3_SLT     = 3'b010;
  localparam logic [2:0] F3_SLTU    = 3'b011;
  localparam logic [2:0] F3_XOR     = 3'b100;
  localparam logic [2:0] F3_SRL_SRA = 3'b101;
  localparam logic [2:0] F3_OR      = 3'b110;
  localparam logic [2:0] F3_AND     = 3'b111;

  typedef struct packed {
    logic [TAG_W-1:0] tag;
    logic             rdy;
    logic [XLEN-1:0]  data;
  } rs_opnd_t;

  typedef struct packed {
    logic             valid;
    logic [4:0]       opcode;
    logic [2:0]       funct3;
    logic             funct7;
    rs_opnd_t         rs1;
    rs_opnd_t         rs2;
    logic [XLEN-1:0]  imm;
    logic [XLEN-1:0]  pc;
    logic [ROB_W-1:0] rob_idx;
    logic [TAG_W-1:0] rd;
  } rs_entry_t;

  // Capture a broadcast result into a waiting operand whose tag matches.
  function automatic rs_opnd_t wake_opnd(input rs_opnd_t o, input logic cdb_valid,
                                         input logic [TAG_W-1:0] cdb_tag,
                                         input logic [XLEN-1:0] cdb_data);
    rs_opnd_t r;
    r = o;
    if (cdb_valid && !o.rdy && (o.tag == cdb_tag)) begin
      r.rdy  = 1'b1;
      r.data = cdb_data;
    end
    return r;
  endfunction

endpackage

// File: rtl/alu_rs_select.sv
// rtl/alu_rs_select.sv - lowest-index-first issue priority encoder
module rs_select #(
  parameter int N = 4
) (
  input  logic [N-1:0] req,
  output logic [N-1:0] one_hot,
  output logic         found
);

  // Entry 0 is oldest, so the first set request wins.
  always_comb begin
    one_hot = '0;
    found   = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (req[i] && !found) begin
        one_hot[i] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/alu_rs.sv
// rtl/alu_rs.sv - age-ordered collapsing reservation station feeding the ALU
module alu_rs
  import alu_rs_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             dis_valid,
  output logic             dis_ready,
  input  logic [4:0]       dis_opcode,
  input  logic [2:0]       dis_funct3,
  input  logic             dis_funct7,
  input  logic [TAG_W-1:0] dis_rs1_tag,
  input  logic             dis_rs1_rdy,
  input  logic [XLEN-1:0]  dis_rs1_data,
  input  logic [TAG_W-1:0] dis_rs2_tag,
  input  logic             dis_rs2_rdy,
  input  logic [XLEN-1:0]  dis_rs2_data,
  input  logic [XLEN-1:0]  dis_imm,
  input  logic [XLEN-1:0]  dis_pc,
  input  logic [ROB_W-1:0] dis_rob_idx,
  input  logic [TAG_W-1:0] dis_rd,
  input  logic             cdb_valid,
  input  logic [TAG_W-1:0] cdb_tag,
  input  logic [XLEN-1:0]  cdb_data,
  output logic             alu_i_valid,
  output logic [4:0]       opcode,
  output logic [2:0]       funct3,
  output logic             funct7,
  output logic [XLEN-1:0]  rs1_data,
  output logic [XLEN-1:0]  rs2_data,
  output logic [XLEN-1:0]  imm,
  output logic [XLEN-1:0]  pc,
  output logic [ROB_W-1:0] alu_i_rob_idx,
  output logic [TAG_W-1:0] alu_i_rd
);

  localparam int CW = $clog2(DEPTH + 1);

  rs_entry_t        ent_q [DEPTH];
  rs_entry_t        ent_d [DEPTH];
  rs_entry_t        woken [DEPTH];
  rs_entry_t        dis_ent;
  rs_entry_t        sel_ent;
  logic [CW-1:0]    count_q;
  logic [CW-1:0]    count_d;
  logic [CW-1:0]    count_rem;
  logic [CW-1:0]    sel_idx;
  logic [DEPTH-1:0] req;
  logic [DEPTH-1:0] sel_oh;
  logic             found;
  logic             issue;
  logic             dis_fire;

  assign dis_ready = (count_q < CW'(DEPTH));
  assign dis_fire  = dis_valid && dis_ready && !flush;
  assign issue     = found && !flush;

  // An entry may issue once both operands hold their values.
  always_comb begin
    req = '0;
    for (int i = 0; i < DEPTH; i++) begin
      req[i] = ent_q[i].valid && ent_q[i].rs1.rdy && ent_q[i].rs2.rdy;
    end
  end

  rs_select #(.N(DEPTH)) u_select (
    .req     (req),
    .one_hot (sel_oh),
    .found   (found)
  );

  // Output mux; defaults to entry 0 so nothing undriven leaks out when idle.
  always_comb begin
    sel_ent = ent_q[0];
    sel_idx = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (sel_oh[i]) begin
        sel_ent = ent_q[i];
        sel_idx = CW'(i);
      end
    end
  end

  assign alu_i_valid   = issue;
  assign opcode        = sel_ent.opcode;
  assign funct3        = sel_ent.funct3;
  assign funct7        = sel_ent.funct7;
  assign rs1_data      = sel_ent.rs1.data;
  assign rs2_data      = sel_ent.rs2.data;
  assign imm           = sel_ent.imm;
  assign pc            = sel_ent.pc;
  assign alu_i_rob_idx = sel_ent.rob_idx;
  assign alu_i_rd      = sel_ent.rd;

  // Incoming entry, including capture of a result broadcast in the same cycle.
  always_comb begin
    dis_ent         = '0;
    dis_ent.valid   = 1'b1;
    dis_ent.opcode  = dis_opcode;
    dis_ent.funct3  = dis_funct3;
    dis_ent.funct7  = dis_funct7;
    dis_ent.rs1     = wake_opnd({dis_rs1_tag, dis_rs1_rdy, dis_rs1_data}, cdb_valid, cdb_tag, cdb_data);
    dis_ent.rs2     = wake_opnd({dis_rs2_tag, dis_rs2_rdy, dis_rs2_data}, cdb_valid, cdb_tag, cdb_data);
    dis_ent.imm     = dis_imm;
    dis_ent.pc      = dis_pc;
    dis_ent.rob_idx = dis_rob_idx;
    dis_ent.rd      = dis_rd;
  end

  // Next queue image: wake, collapse over the issued slot, then append at the tail.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      woken[i] = ent_q[i];
      if (ent_q[i].valid) begin
        woken[i].rs1 = wake_opnd(ent_q[i].rs1, cdb_valid, cdb_tag, cdb_data);
        woken[i].rs2 = wake_opnd(ent_q[i].rs2, cdb_valid, cdb_tag, cdb_data);
      end
    end
    for (int i = 0; i < DEPTH; i++) begin
      ent_d[i] = woken[i];
    end
    if (issue) begin
      for (int i = 0; i < DEPTH - 1; i++) begin
        if (CW'(i) >= sel_idx) begin
          ent_d[i] = woken[i + 1];
        end
      end
      ent_d[DEPTH-1].valid = 1'b0;
    end
    count_rem = count_q - CW'(issue);
    for (int i = 0; i < DEPTH; i++) begin
      if (dis_fire && (CW'(i) == count_rem)) begin
        ent_d[i] = dis_ent;
      end
    end
    count_d = count_rem + CW'(dis_fire);
  end

  // Queue state; flush kills every entry but keeps stale payload.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        ent_q[i] <= '0;
      end
    end else if (flush) begin
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        ent_q[i].valid <= 1'b0;
      end
    end else begin
      count_q <= count_d;
      ent_q   <= ent_d;
    end
  end

endmodule

// File: tb/tb_alu_rs.sv
// tb/tb_alu_rs.sv - randomized and directed bench for alu_rs against a queue model
module tb_alu_rs;
  import alu_rs_pkg::*;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n, flush, dis_valid, dis_ready;
  logic [4:0]  dis_opcode;
  logic [2:0]  dis_funct3;
  logic        dis_funct7;
  logic [6:0]  dis_rs1_tag, dis_rs2_tag, dis_rd, cdb_tag, alu_i_rd;
  logic        dis_rs1_rdy, dis_rs2_rdy, cdb_valid, alu_i_valid;
  logic [31:0] dis_rs1_data, dis_rs2_data, dis_imm, dis_pc, cdb_data;
  logic [2:0]  dis_rob_idx, alu_i_rob_idx;
  logic [4:0]  opcode;
  logic [2:0]  funct3;
  logic        funct7;
  logic [31:0] rs1_data, rs2_data, imm, pc;

  always #5 clk = ~clk;

  alu_rs #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .dis_valid(dis_valid), .dis_ready(dis_ready),
    .dis_opcode(dis_opcode), .dis_funct3(dis_funct3), .dis_funct7(dis_funct7),
    .dis_rs1_tag(dis_rs1_tag), .dis_rs1_rdy(dis_rs1_rdy), .dis_rs1_data(dis_rs1_data),
    .dis_rs2_tag(dis_rs2_tag), .dis_rs2_rdy(dis_rs2_rdy), .dis_rs2_data(dis_rs2_data),
    .dis_imm(dis_imm), .dis_pc(dis_pc), .dis_rob_idx(dis_rob_idx), .dis_rd(dis_rd),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
    .alu_i_valid(alu_i_valid), .opcode(opcode), .funct3(funct3), .funct7(funct7),
    .rs1_data(rs1_data), .rs2_data(rs2_data), .imm(imm), .pc(pc),
    .alu_i_rob_idx(alu_i_rob_idx), .alu_i_rd(alu_i_rd)
  );

  typedef struct {
    logic [4:0]  op;
    logic [2:0]  f3;
    logic        f7;
    logic [6:0]  t1;
    logic        r1;
    logic [31:0] d1;
    logic [6:0]  t2;
    logic        r2;
    logic [31:0] d2;
    logic [31:0] im;
    logic [31:0] p;
    logic [2:0]  rob;
    logic [6:0]  rd;
  } m_ent_t;

  m_ent_t mq[$];
  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic int oldest_ready();
    foreach (mq[i]) if (mq[i].r1 && mq[i].r2) return i;
    return -1;
  endfunction

  // Compare outputs against the model mid-cycle, then advance model and DUT one edge.
  task automatic step();
    int     k;
    bit     can_dis;
    m_ent_t e;
    m_ent_t ne;
    @(negedge clk);
    k = oldest_ready();
    chk("dis_ready", 32'(dis_ready), 32'(mq.size() < DEPTH));
    chk("alu_i_valid", 32'(alu_i_valid), 32'(k >= 0 && !flush));
    if (k >= 0 && !flush) begin
      e = mq[k];
      chk("opcode", 32'(opcode), 32'(e.op));
      chk("funct3", 32'(funct3), 32'(e.f3));
      chk("funct7", 32'(funct7), 32'(e.f7));
      chk("rs1_data", rs1_data, e.d1);
      chk("rs2_data", rs2_data, e.d2);
      chk("imm", imm, e.im);
      chk("pc", pc, e.p);
      chk("rob_idx", 32'(alu_i_rob_idx), 32'(e.rob));
      chk("rd", 32'(alu_i_rd), 32'(e.rd));
    end
    if (!rst_n || flush) begin
      mq.delete();
    end else begin
      can_dis = (mq.size() < DEPTH);
      if (k >= 0) mq.delete(k);
      foreach (mq[i]) begin
        if (cdb_valid && !mq[i].r1 && mq[i].t1 == cdb_tag) begin mq[i].r1 = 1'b1; mq[i].d1 = cdb_data; end
        if (cdb_valid && !mq[i].r2 && mq[i].t2 == cdb_tag) begin mq[i].r2 = 1'b1; mq[i].d2 = cdb_data; end
      end
      if (dis_valid && can_dis) begin
        ne = '{dis_opcode, dis_funct3, dis_funct7, dis_rs1_tag, dis_rs1_rdy, dis_rs1_data,
               dis_rs2_tag, dis_rs2_rdy, dis_rs2_data, dis_imm, dis_pc, dis_rob_idx, dis_rd};
        if (cdb_valid && !ne.r1 && ne.t1 == cdb_tag) begin ne.r1 = 1'b1; ne.d1 = cdb_data; end
        if (cdb_valid && !ne.r2 && ne.t2 == cdb_tag) begin ne.r2 = 1'b1; ne.d2 = cdb_data; end
        mq.push_back(ne);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rst_n = 1'b1; flush = 1'b0; dis_valid = 1'b0; cdb_valid = 1'b0;
    cdb_tag = '0; cdb_data = '0;
  endtask

  task automatic set_dis(input logic [6:0] t1, input logic r1, input logic [31:0] d1,
                         input logic [6:0] t2, input logic r2, input logic [31:0] d2,
                         input logic [2:0] rob);
    dis_valid = 1'b1; dis_opcode = OP_R_TYPE; dis_funct3 = F3_ADD_SUB; dis_funct7 = 1'b0;
    dis_rs1_tag = t1; dis_rs1_rdy = r1; dis_rs1_data = d1;
    dis_rs2_tag = t2; dis_rs2_rdy = r2; dis_rs2_data = d2;
    dis_imm = 32'h0; dis_pc = 32'h1000 + 32'(rob) * 4; dis_rob_idx = rob; dis_rd = 7'd40 + 7'(rob);
  endtask

  task automatic set_cdb(input logic [6:0] t, input logic [31:0] d);
    cdb_valid = 1'b1; cdb_tag = t; cdb_data = d;
  endtask

  initial begin
    idle();
    set_dis(0, 1, 0, 0, 1, 0, 0);
    dis_valid = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    idle();
    mq.delete();

    // Single ready ADD issues the cycle after dispatch, then queue empties
    set_dis(1, 1, 5, 2, 1, 7, 0);
    step();
    idle(); #1;
    chk("r030_valid", 32'(alu_i_valid), 32'd1);
    chk("r030_rs1", rs1_data, 32'd5);
    chk("r030_rs2", rs2_data, 32'd7);
    step();
    idle(); #1;
    chk("r030_empty", 32'(alu_i_valid), 32'd0);

    // Younger ready entry bypasses an older waiting one; wakeup then releases the older
    set_dis(1, 1, 32'h11, 12, 0, 0, 1);
    step();
    set_dis(1, 1, 2, 2, 1, 3, 2);
    step();
    idle(); set_cdb(12, 32'h10); #1;
    chk("r031_b_first", 32'(alu_i_rob_idx), 32'd2);
    step();
    idle(); #1;
    chk("r031_a_rob", 32'(alu_i_rob_idx), 32'd1);
    chk("r031_a_rs2", rs2_data, 32'h10);
    step();

    // Same-cycle capture at dispatch
    idle(); set_dis(3, 0, 0, 2, 1, 9, 3); set_cdb(3, 32'hABCD);
    step();
    idle(); #1;
    chk("r032_valid", 32'(alu_i_valid), 32'd1);
    chk("r032_rs1", rs1_data, 32'hABCD);
    step();

    // Full queue, middle entry woken, age order of the rest preserved
    for (int i = 0; i < 4; i++) begin
      idle();
      set_dis((i == 2) ? 7'd22 : (i == 3) ? 7'd23 : 7'd20, 0, 0, 2, 1, 32'(i), 3'(i));
      step();
    end
    idle(); #1;
    chk("r033_full", 32'(dis_ready), 32'd0);
    set_cdb(22, 32'h22);
    step();
    idle(); #1;
    chk("r033_e2_rob", 32'(alu_i_rob_idx), 32'd2);
    chk("r033_no_credit", 32'(dis_ready), 32'd0);
    step();
    idle(); #1;
    chk("r033_credit", 32'(dis_ready), 32'd1);
    set_cdb(20, 32'h20);
    step();
    idle(); #1;
    chk("r033_order0", 32'(alu_i_rob_idx), 32'd0);
    step();
    idle(); #1;
    chk("r033_order1", 32'(alu_i_rob_idx), 32'd1);
    set_cdb(23, 32'h23);
    step();
    idle(); #1;
    chk("r033_order3", 32'(alu_i_rob_idx), 32'd3);
    step();

    // Flush with ready entries pending and a dispatch offered
    for (int i = 0; i < 3; i++) begin
      idle(); set_dis(30, 0, 0, 2, 1, 32'(i), 3'(4 + i));
      step();
    end
    idle(); set_cdb(30, 32'h30);
    step();
    idle(); set_dis(1, 1, 1, 2, 1, 2, 7); flush = 1'b1; #1;
    chk("r034_forced_low", 32'(alu_i_valid), 32'd0);
    step();
    idle(); #1;
    chk("r034_empty", 32'(alu_i_valid), 32'd0);
    chk("r034_ready", 32'(dis_ready), 32'd1);
    repeat (3) step();

    // Reset mid-traffic discards pending dispatch and wakeup
    for (int i = 0; i < 2; i++) begin
      idle(); set_dis(40, 0, 0, 2, 1, 32'(i), 3'(i));
      step();
    end
    idle(); set_dis(1, 1, 1, 2, 1, 1, 5); set_cdb(40, 32'h40); rst_n = 1'b0;
    step();
    idle(); #1;
    chk("r035_valid", 32'(alu_i_valid), 32'd0);
    chk("r035_ready", 32'(dis_ready), 32'd1);
    repeat (2) step();

    // Randomized traffic against the model
    for (int c = 0; c < 2000; c++) begin
      rst_n        = ($urandom_range(0, 199) != 0);
      flush        = ($urandom_range(0, 49) == 0);
      dis_valid    = ($urandom_range(0, 99) < 60);
      dis_opcode   = ($urandom_range(0, 1) != 0) ? OP_R_TYPE : OP_I_TYPE;
      dis_funct3   = 3'($urandom);
      dis_funct7   = 1'($urandom);
      dis_rs1_tag  = 7'($urandom_range(0, 7));
      dis_rs1_rdy  = 1'($urandom);
      dis_rs1_data = $urandom;
      dis_rs2_tag  = 7'($urandom_range(0, 7));
      dis_rs2_rdy  = 1'($urandom);
      dis_rs2_data = $urandom;
      dis_imm      = $urandom;
      dis_pc       = $urandom;
      dis_rob_idx  = 3'($urandom);
      dis_rd       = 7'($urandom);
      cdb_valid    = ($urandom_range(0, 99) < 40);
      cdb_tag      = 7'($urandom_range(0, 7));
      cdb_data     = $urandom;
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/alu_rs.md
ALU_RS -- requirements
Module: alu_rs

Interface
REQ-001 The module SHALL have parameter DEPTH, default 4, meaning number of reservation-station entries (power of two, 2..8).
REQ-002 The module SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 The module SHALL have port rst_n, input, 1; reset is synchronous and active-low.
REQ-004 The module SHALL have port flush, input, 1, commit-time recovery: kill every entry.
REQ-005 The module SHALL have ports dis_valid input 1 and dis_ready output 1, the dispatch handshake.
REQ-006 The module SHALL have ports dis_opcode input 5, dis_funct3 input 3, dis_funct7 input 1, the decoded operation.
REQ-007 The module SHALL have ports dis_rs1_tag input 7, dis_rs1_rdy input 1, dis_rs1_data input 32, source 1 tag/ready/value.
REQ-008 The module SHALL have ports dis_rs2_tag input 7, dis_rs2_rdy input 1, dis_rs2_data input 32, source 2 tag/ready/value.
REQ-009 The module SHALL have ports dis_imm input 32, dis_pc input 32, dis_rob_idx input 3, dis_rd input 7.
REQ-010 The module SHALL have ports cdb_valid input 1, cdb_tag input 7, cdb_data input 32, the result broadcast.
REQ-011 The module SHALL have outputs alu_i_valid 1, opcode 5, funct3 3, funct7 1, rs1_data 32, rs2_data 32, imm 32, pc 32, alu_i_rob_idx 3, alu_i_rd 7, driving the ALU.

Function
REQ-012 Entries SHALL be kept age-ordered in a collapsing queue; entry 0 is oldest; count ranges 0..DEPTH.
REQ-013 dis_ready SHALL equal (count < DEPTH); no same-cycle credit from an issuing entry.
REQ-014 A dispatch SHALL occur when dis_valid && dis_ready && !flush; the entry is written at the next edge at the tail, after collapse.
REQ-015 An entry SHALL be issuable when valid and both operand ready bits are set; the lowest-index issuable entry is selected.
REQ-016 Select and outputs SHALL be combinational from stored entries; alu_i_valid = any issuable && !flush; the ALU always accepts.
REQ-017 The issued entry SHALL be removed at the next edge; younger entries shift down by one; at most one issue and one dispatch per cycle.
REQ-018 Earliest issue SHALL be the cycle after the dispatch edge; there is no dispatch-to-issue bypass.
REQ-019 Wakeup: when cdb_valid, every valid entry operand with rdy=0 and tag==cdb_tag SHALL set rdy and capture cdb_data at the edge.
REQ-020 A dispatching operand with rdy=0 and tag==cdb_tag while cdb_valid SHALL be stored as ready with cdb_data (same-cycle capture).
REQ-021 An entry woken at edge t SHALL be issuable in the cycle after t; the broadcast is not forwarded to the output in the same cycle.
REQ-022 Operands not consumed by the opcode (e.g. rs2 of I_TYPE, rs1 of LUI/AUIPC/JAL) SHALL be dispatched with rdy=1 by upstream; alu_rs does not decode them.
REQ-023 flush SHALL clear all valid bits at the next edge, drop any dispatch that cycle, and force alu_i_valid=0 that cycle.
REQ-024 Simultaneous dispatch and issue when full SHALL be impossible (dis_ready=0); when not full, both SHALL complete and count is unchanged.
REQ-025 Data outputs SHALL be don't-care when alu_i_valid=0 but SHALL not produce X from unwritten entries (mux selects entry 0 by default).

Reset
REQ-026 When rst_n=0 at an edge, all entry valid bits and ready bits SHALL clear and count=0; payload registers need not reset.
REQ-027 After reset alu_i_valid=0 and dis_ready=1; reset during a pending dispatch or wakeup SHALL discard it.

Structure
REQ-028 Opcode/funct3 encodings, ROB index width (3) and physical tag width (7) SHALL come from the shared core package; the rs-entry struct type SHALL be defined there.
REQ-029 The issue-select priority encoder SHALL be a sub-module named rs_select (valid vector in, one-hot and found out).

Verification
REQ-030 Dispatch ADD with both rdy=1, rs1=5, rs2=7 -> next cycle alu_i_valid=1, rs1_data=5, rs2_data=7, then queue empty.
REQ-031 Dispatch A (rs2 tag 12 not ready) then B (ready) -> B issues first; cdb_tag=12 data 0x10 -> A issues the following cycle with rs2_data=0x10.
REQ-032 Dispatch with rs1 tag 3 not ready while cdb_valid, cdb_tag=3, data 0xABCD -> entry issues next cycle with rs1_data=0xABCD.
REQ-033 Fill 4 entries all waiting -> dis_ready=0; wake entry 2 -> it issues, dis_ready returns 1, entries 0,1,3 keep age order.
REQ-034 Three entries pending, assert flush with dis_valid=1 -> alu_i_valid=0 that cycle, count=0 next, dropped dispatch never issues.
REQ-035 Assert rst_n=0 for one edge mid-traffic -> count=0, alu_i_valid=0, dis_ready=1 next cycle.
